hdb3_polarity: RTL
==================

# hdb3_polarity

Final HDB3 encoder stage. Consumes the 2-bit symbol stream (0 / 1 / V / B) from the B-insertion stage and assigns line polarity: marks and B pulses alternate, V pulses repeat the previous pulse polarity. It drives the two-rail (pos/neg) line interface and a signed bipolar code. It also monitors the stream: it flags zero runs the upstream stages should have broken, and tracks running DC disparity.

## Interface
- DW, 4: width of the signed running-disparity counter (two's complement, saturating).
- MAX_ZERO_RUN, 3: longest legal run of consecutive 0 symbols; a longer run raises `zero_run_err`.

- clk  in  1  rising-edge clock, one symbol per enabled cycle.
- rst_n  in  1  reset, asynchronous and active-low; one clock domain, no other reset.
- in_valid  in  1  `code_in` carries a symbol this cycle.
- code_in  in  2  symbol: 2'b00=0, 2'b01=1 (mark), 2'b11=V, 2'b10=B.
- out_valid  out  1  registered copy of `in_valid`.
- pos_out  out  1  positive-rail pulse.
- neg_out  out  1  negative-rail pulse.
- bip_out  out  2  signed line level: 2'b01=+1, 2'b11=-1, 2'b00=0; never 2'b10.
- zero_run_err  out  1  one-cycle pulse when a zero run exceeds MAX_ZERO_RUN.
- disparity  out  DW  running sum of emitted levels (+1 per positive pulse, -1 per negative pulse), signed, saturating.

## Operation
- State: `last_pol` (1=positive), `zrun` counter (width ceil(log2(MAX_ZERO_RUN+2))), `disparity` register.
- Reset values: `last_pol`=0, so the first mark or B after reset is positive. `zrun`=0, `disparity`=0. Outputs `out_valid`, `pos_out`, `neg_out`, `zero_run_err`=0 and `bip_out`=2'b00.
- All updates happen only on cycles with `in_valid`=1. With `in_valid`=0, all state holds and the cycle-after outputs are `out_valid`=0, rails 0, `bip_out`=00, `zero_run_err`=0. `disparity` holds its value.
- Symbol rules (pol = polarity emitted):
  - 0: no pulse; `last_pol` unchanged; `zrun` increments, saturating at MAX_ZERO_RUN+1.
  - 1 or B: pol = ~`last_pol`; `last_pol` <= pol; `zrun` <= 0.
  - V: pol = `last_pol` (a deliberate bipolar violation); `last_pol` unchanged; `zrun` <= 0.
- Rails: for a pulse, `pos_out`=pol and `neg_out`=~pol. Both rails are 0 for a 0 symbol. Both rails high is illegal and must never occur.
- `bip_out` follows the rails: 01 when `pos_out`, 11 when `neg_out`, else 00.
- `zero_run_err` pulses on the cycle after the valid 0 symbol that makes `zrun` reach MAX_ZERO_RUN+1. It fires once per run. It re-arms only after a nonzero symbol or reset.
- `disparity` adds +1 for a positive pulse and -1 for a negative pulse. It clamps at 2^(DW-1)-1 and -2^(DW-1), and never wraps.

## Timing
- Latency is exactly 1 cycle: the symbol registered at edge N drives every output from edge N until edge N+1. All outputs are registered, with no combinational path from inputs to outputs.
- Throughput is one symbol per cycle, and back-to-back valid symbols are supported. `in_valid` gaps do not alter polarity history: a V after a gap still repeats the pre-gap `last_pol`.
- `disparity` reflects all pulses up to and including the one on `bip_out` in the same cycle.
- Asynchronous reset mid-stream forces all outputs to reset values immediately. The first symbol after deassertion sees `last_pol`=0.
- A V or B as the very first symbol after reset is legal. V emits negative (repeats `last_pol`=0); B emits positive.

## Test plan
- Reset then marks: valid stream 1,1,1,1 -> `bip_out` +1,-1,+1,-1 one cycle later; `disparity` 1,0,1,0.
- HDB3 substitution: stream 1,0,0,0,V,1,B,0,0,V -> levels +1,0,0,0,+1,-1,+1,0,0,+1; `zero_run_err` never asserts; `disparity` ends at 3.
- Zero-run monitor: 1 followed by five 0s -> `zero_run_err` pulses exactly once, on the output cycle of the fourth 0; it pulses again only after a further 1 and then four 0s.
- Valid gaps: 1, idle×3, V, idle, 1 -> idle cycles show `out_valid`=0 and `bip_out`=00; V emits +1 and the final 1 emits -1; `zrun` is unaffected by idles.
- Saturation (DW=4): 20× alternating 1,V pairs, each pair +,+ then -,- -> `disparity` stays within -8..7 without wrap. A run of sixteen 1,B,V,V-style positive-biased patterns clamps at 7.
- Async reset: assert `rst_n`=0 mid-cycle during a pulse -> rails drop immediately and `disparity`=0. After release, stream 1 emits +1.

Source files
------------

// File: rtl/hdb3_polarity.sv
// hdb3_polarity: final HDB3 stage; assigns line polarity to 0/1/V/B symbols,
// drives two-rail and signed bipolar outputs, monitors zero runs and DC disparity.
module hdb3_polarity #(
    parameter int DW           = 4,
    parameter int MAX_ZERO_RUN = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    input  logic [1:0]           i_code_in,
    output logic                 o_out_valid,
    output logic                 o_pos_out,
    output logic                 o_neg_out,
    output logic [1:0]           o_bip_out,
    output logic                 o_zero_run_err,
    output logic signed [DW-1:0] o_disparity
);
    localparam int                   ZW   = $clog2(MAX_ZERO_RUN + 2);
    localparam logic [ZW-1:0]        ZMAX = ZW'(MAX_ZERO_RUN);
    localparam logic [ZW-1:0]        ZSAT = ZW'(MAX_ZERO_RUN + 1);
    localparam logic [ZW-1:0]        ZONE = ZW'(1);
    localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] DONE = DW'(1);

    logic                 r_last_pol;
    logic [ZW-1:0]        r_zrun;
    logic signed [DW-1:0] r_disp;
    logic                 r_valid;
    logic                 r_pos;
    logic                 r_neg;
    logic                 r_err;

    logic                 w_pulse;
    logic                 w_zero;
    logic                 w_toggle;
    logic                 w_pol;
    logic [ZW-1:0]        w_zrun_next;
    logic signed [DW-1:0] w_disp_next;

    // Marks (01) and B pulses (10) alternate; V (11) repeats the last polarity.
    assign w_pulse  = i_in_valid & (i_code_in != 2'b00);
    assign w_zero   = i_in_valid & (i_code_in == 2'b00);
    assign w_toggle = i_code_in[0] ^ i_code_in[1];
    assign w_pol    = w_toggle ? ~r_last_pol : r_last_pol;

    always_comb begin
        w_zrun_next = w_zero  ? ((r_zrun == ZSAT) ? r_zrun : r_zrun + ZONE) :
                      w_pulse ? '0 : r_zrun;
        w_disp_next = !w_pulse ? r_disp :
                      w_pol    ? ((r_disp == DMAX) ? r_disp : r_disp + DONE) :
                                 ((r_disp == DMIN) ? r_disp : r_disp - DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_pol <= 1'b0;
            r_zrun     <= '0;
            r_disp     <= '0;
            r_valid    <= 1'b0;
            r_pos      <= 1'b0;
            r_neg      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid    <= i_in_valid;
            r_pos      <= w_pulse & w_pol;
            r_neg      <= w_pulse & ~w_pol;
            r_err      <= w_zero & (r_zrun == ZMAX);
            r_zrun     <= w_zrun_next;
            r_disp     <= w_disp_next;
            if (w_pulse) r_last_pol <= w_pol;
        end
    end

    assign o_out_valid    = r_valid;
    assign o_pos_out      = r_pos;
    assign o_neg_out      = r_neg;
    assign o_bip_out      = {r_neg, r_pos | r_neg};
    assign o_zero_run_err = r_err;
    assign o_disparity    = r_disp;
endmodule
